// File: rtl/wb_led_pkg.sv
// Shared types and constants for the WISHBONE LED sequencer: FSM states,
// pattern modes, the byte select value and the pattern-advance function.
package wb_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_CNT    = 2'b11;

    localparam logic [1:0] SEL_LOW = 2'b01;

    function automatic logic is_one_hot(input logic [3:0] pat);
        return (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);
    endfunction

    // Returns {direction_right_next, pattern_next}. The direction only moves
    // in bounce mode; a non-one-hot pattern restarts the bounce at 0001.
    function automatic logic [4:0] advance_pattern(input logic [3:0] pat,
                                                   input logic [1:0] mode,
                                                   input logic       dir_right);
        logic [3:0] nxt;
        logic       nxt_right;
        nxt       = pat;
        nxt_right = dir_right;
        case (mode)
            MODE_ROL: nxt = {pat[2:0], pat[3]};
            MODE_ROR: nxt = {pat[0], pat[3:1]};
            MODE_BOUNCE: begin
                if (!is_one_hot(pat)) begin
                    nxt       = 4'b0001;
                    nxt_right = 1'b0;
                end else if (!dir_right) begin
                    if (pat[3]) begin
                        nxt       = 4'b0100;
                        nxt_right = 1'b1;
                    end else begin
                        nxt = pat << 1;
                    end
                end else begin
                    if (pat[0]) begin
                        nxt       = 4'b0010;
                        nxt_right = 1'b0;
                    end else begin
                        nxt = pat >> 1;
                    end
                end
            end
            default: nxt = pat + 4'd1;
        endcase
        return {nxt_right, nxt};
    endfunction

endpackage

// File: rtl/wb_led_tick_gen.sv
// Clock divider producing one pattern-step tick every TICK_DIV cycles, held
// in a pending flag until the sequencer FSM consumes it.
module wb_led_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic consume,
    output logic pending
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] div_q;
    logic          wrap;

    assign wrap = enable && (div_q == CW'(TICK_DIV - 1));

    // A wrap while pending is already set is simply absorbed (tick dropped).
    // Disabling also discards any pending tick so the sequencer stays idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            pending <= 1'b0;
        end else if (!enable) begin
            div_q   <= '0;
            pending <= 1'b0;
        end else begin
            if (wrap) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (wrap) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wishbone_led_sequencer.sv
// WISHBONE master writing a 4-bit LED pattern to a GPIO data register once per
// divided tick. Define READBACK_EN to follow each write with a verifying read.
module wishbone_led_sequencer
    import wb_led_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter logic [31:0] GPIO_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [1:0]  sel_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    output logic [3:0]  pattern,
    output logic        busy,
    output logic        err,
`ifdef READBACK_EN
    output logic        mismatch,
`endif
    output logic [1:0]  state_dbg
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Handshake: a beat completes on any clk edge where cyc_o, stb_o and ack_i
    // are all high; bus outputs are held stable from cyc_o rise until then, and
    // ack_i is ignored whenever cyc_o is low.
    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [3:0]    pat_q;
    logic          dir_q;
    logic          nxt_dir_q;
    logic          pending;
    logic          consume;
    logic [4:0]    adv;
    logic          timed_out;

    assign consume   = (state == IDLE) && pending;
    assign adv       = advance_pattern(pat_q, mode, dir_q);
    assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
    assign state_dbg = state;

`ifdef READBACK_EN
    logic unused_dat;
    assign unused_dat = ^dat_i[31:4];
`else
    logic unused_dat;
    assign unused_dat = ^dat_i;
`endif

    wb_led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .consume(consume),
        .pending(pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            pat_q     <= 4'b0001;
            dir_q     <= 1'b0;
            nxt_dir_q <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            we_o      <= 1'b0;
            sel_o     <= '0;
            stb_o     <= 1'b0;
            cyc_o     <= 1'b0;
            pattern   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef READBACK_EN
            mismatch  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state     <= WRITE;
                        to_cnt    <= '0;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        we_o      <= 1'b1;
                        busy      <= 1'b1;
                        adr_o     <= GPIO_ADDR;
                        sel_o     <= SEL_LOW;
                        dat_o     <= {28'd0, adv[3:0]};
                        nxt_dir_q <= adv[4];
                    end
                end
                WRITE: begin
                    if (ack_i) begin
                        // dat_o still carries the pattern being committed.
                        pat_q   <= dat_o[3:0];
                        pattern <= dat_o[3:0];
                        dir_q   <= nxt_dir_q;
`ifdef READBACK_EN
                        state   <= READ;
                        to_cnt  <= '0;
                        we_o    <= 1'b0;
`else
                        state   <= IDLE;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                        busy    <= 1'b0;
`endif
                    end else if (timed_out) begin
                        state <= IDLE;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`ifdef READBACK_EN
                READ: begin
                    if (ack_i || timed_out) begin
                        state <= IDLE;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        busy  <= 1'b0;
                        if (ack_i) begin
                            if (dat_i[3:0] != dat_o[3:0]) begin
                                mismatch <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cyc_o <= 1'b0;
                    stb_o <= 1'b0;
                    we_o  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_led_sequencer.sv
// Directed bench for wishbone_led_sequencer: a short-timeout instance for
// pattern, timeout and reset checks plus a long-timeout instance for tick overlap.
module tb_wishbone_led_sequencer;
    import wb_led_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic [1:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;
    logic [3:0]  pattern;
    logic        busy;
    logic        err;
    logic [1:0]  state_dbg;
`ifdef READBACK_EN
    logic        mismatch;
    logic        mismatch_l;
`endif

    logic        en_l;
    logic        ack_l;
    logic [31:0] adr_l;
    logic [31:0] dat_l;
    logic        we_l;
    logic [1:0]  sel_l;
    logic        stb_l;
    logic        cyc_l;
    logic [3:0]  pat_l;
    logic        busy_l;
    logic        err_l;
    logic [1:0]  st_l;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ack_wait = 1;
    logic ack_en = 1'b1;
    int slave_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    wishbone_led_sequencer #(.TICK_DIV(4), .GPIO_ADDR(32'h0), .TIMEOUT(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .pattern(pattern),
        .busy(busy), .err(err),
`ifdef READBACK_EN
        .mismatch(mismatch),
`endif
        .state_dbg(state_dbg)
    );

    wishbone_led_sequencer #(.TICK_DIV(4), .GPIO_ADDR(32'h0), .TIMEOUT(8)) dut_long (
        .clk(clk), .rst(rst), .enable(en_l), .mode(mode),
        .adr_o(adr_l), .dat_o(dat_l), .dat_i(32'h0), .we_o(we_l), .sel_o(sel_l),
        .stb_o(stb_l), .cyc_o(cyc_l), .ack_i(ack_l), .pattern(pat_l),
        .busy(busy_l), .err(err_l),
`ifdef READBACK_EN
        .mismatch(mismatch_l),
`endif
        .state_dbg(st_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave model: acks writes after ack_wait wait states, reads with none.
    always @(negedge clk) begin
        if (!rst) begin
            ack_i = 1'b0;
            slave_cnt = 0;
        end else if (ack_i) begin
            ack_i = 1'b0;
            slave_cnt = 0;
        end else if (cyc_o && stb_o && ack_en) begin
            if (slave_cnt >= (we_o ? ack_wait : 0)) ack_i = 1'b1;
            else slave_cnt++;
        end else begin
            slave_cnt = 0;
        end
    end

    // Monitor: logs every completed beat on the short-timeout instance.
    always @(posedge clk) begin
        if (rst && cyc_o && stb_o && ack_i) begin
            check("beat_sel", sel_o, 32'h1);
            check("beat_adr", adr_o, 32'h0);
            check("beat_busy", busy, 32'h1);
            if (we_o) begin
                obs_q.push_back(dat_o[3:0]);
                check("beat_dat_upper", dat_o[31:4], 32'h0);
                wr_cnt++;
            end else begin
                rd_cnt++;
            end
        end
    end

    task automatic check_scoreboard(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_dat"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic run_writes(input int n, input string tag);
        int target;
        int k;
        target = wr_cnt + n;
        enable = 1'b1;
        k = 0;
        while (wr_cnt < target && k < 300) begin
            step();
            k++;
        end
        enable = 1'b0;
        check({tag, "_writes_done"}, (wr_cnt >= target), 32'h1);
        repeat (6) step();
        check({tag, "_no_extra"}, wr_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int rd_before;
        rst = 1'b0; enable = 1'b0; mode = MODE_ROL; dat_i = 32'h0;
        en_l = 1'b0; ack_l = 1'b0;
        repeat (3) step();
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_pattern", pattern, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", state_dbg, 0);
        #2 rst = 1'b1;

        // T1: rotate-left from 0001, one wait state.
        mode = MODE_ROL; ack_wait = 1;
        exp_q.push_back(4'h2); exp_q.push_back(4'h4);
        exp_q.push_back(4'h8); exp_q.push_back(4'h1);
        run_writes(4, "t1");
        check_scoreboard("t1");
        check("t1_pattern", pattern, 4'h1);
        check("t1_busy_idle", busy, 0);

        // T2: bounce from 0001.
        mode = MODE_BOUNCE;
        exp_q.push_back(4'h2); exp_q.push_back(4'h4); exp_q.push_back(4'h8);
        exp_q.push_back(4'h4); exp_q.push_back(4'h2); exp_q.push_back(4'h1);
        exp_q.push_back(4'h2); exp_q.push_back(4'h4);
        run_writes(8, "t2");
        check_scoreboard("t2");
        check("t2_pattern", pattern, 4'h4);

        // T3: slave never acks -> timeout after 3 cycles, then a retry.
        ack_en = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!cyc_o && k < 20) begin step(); k++; end
        check("t3_rise_seen", cyc_o, 1);
        n = 0;
        while (cyc_o && n < 10) begin n++; step(); end
        check("t3_cyc_len", n, 3);
        check("t3_err", err, 1);
        check("t3_pattern_kept", pattern, 4'h4);
        check("t3_busy_drop", busy, 0);
        k = 0;
        while (!cyc_o && k < 20) begin step(); k++; end
        check("t3_retry_seen", cyc_o, 1);
        check("t3_retry_dat", dat_o, 32'h8);
        ack_wait = 0; ack_en = 1'b1; enable = 1'b0;
        exp_q.push_back(4'h8);
        repeat (6) step();
        check_scoreboard("t3");
        check("t3_pattern_after", pattern, 4'h8);
        check("t3_err_sticky", err, 1);

`ifndef READBACK_EN
        // T4: long wait on the TIMEOUT=8 instance; one tick stays pending.
        mode = MODE_ROL;
        en_l = 1'b1;
        k = 0;
        while (!cyc_l && k < 20) begin step(); k++; end
        check("t4_rise_seen", cyc_l, 1);
        check("t4_first_dat", dat_l, 32'h2);
        repeat (6) step();
        check("t4_hold_cyc", cyc_l, 1);
        check("t4_hold_dat", dat_l, 32'h2);
        ack_l = 1'b1;
        step();
        ack_l = 1'b0;
        check("t4_drop_cyc", cyc_l, 0);
        check("t4_pattern", pat_l, 4'h2);
        step();
        check("t4_followup_cyc", cyc_l, 1);
        check("t4_followup_dat", dat_l, 32'h4);
        ack_l = 1'b1; en_l = 1'b0;
        step();
        ack_l = 1'b0;
        check("t4_pattern2", pat_l, 4'h4);
        n = 0;
        repeat (8) begin step(); if (cyc_l) n++; end
        check("t4_no_more_writes", n, 0);
        check("t4_err", err_l, 0);
`endif

        // T5: asynchronous reset in the middle of a write.
        mode = MODE_ROL; ack_en = 1'b0; enable = 1'b1;
        k = 0;
        while (!cyc_o && k < 20) begin step(); k++; end
        check("t5_rise_seen", cyc_o, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_cyc", cyc_o, 0);
        check("t5_async_stb", stb_o, 0);
        check("t5_async_we", we_o, 0);
        check("t5_async_pattern", pattern, 0);
        check("t5_async_err", err, 0);
`ifdef READBACK_EN
        check("t5_async_mismatch", mismatch, 0);
`endif
        enable = 1'b0; ack_en = 1'b1; ack_wait = 1;
        step(); step();
        rst = 1'b1;
        rd_before = rd_cnt;
        exp_q.push_back(4'h2);
        run_writes(1, "t5");
        check_scoreboard("t5");
        check("t5_pattern", pattern, 4'h2);

`ifdef READBACK_EN
        // T6: read-back returns 0, so the first write flags a mismatch.
        check("t6_read_seen", rd_cnt, rd_before + 1);
        check("t6_mismatch", mismatch, 1);
        check("t6_busy_idle", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
